regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with an integrated busy scoreboard for the pipelined RISC-V datapath. It provides NREAD combinational read ports and two synchronous writeback ports, with optional write-to-read bypass. Per-register busy bits are set at instruction issue and cleared at writeback, so decode can stall on operands that are not ready. Register 0 is hard-wired to zero. A synchronous reset clears all registers and all busy state.

## Interface
Parameters:
- XLEN, 32, data width.
- NREGS, 32, register count (power of two, ≥2); AW = $clog2(NREGS).
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; priority over every other input.
- ra  in  NREAD×AW  read addresses.
- rd  out  NREAD×XLEN  read data.
- rrdy  out  NREAD  operand ready per read port.
- iss_en  in  1  issue strobe: mark iss_rd busy.
- iss_rd  in  AW  destination of issuing instruction.
- we  in  2  writeback enables (port 0, port 1).
- wa  in  2×AW  writeback addresses.
- wd  in  2×XLEN  writeback data.
- nbusy  out  AW+1  registered count of busy registers.

## Operation
- Storage: rf[NREGS] of XLEN bits, plus busy[NREGS].
- Read port i, all combinational:
  - ra[i]==0: rd=0, rrdy=1.
  - BYPASS=1 and some we[k] with wa[k]==ra[i]≠0: rd=wd[k], rrdy=1. Port 1 wins if both ports hit.
  - Otherwise: rd=rf[ra[i]], rrdy=!busy[ra[i]].
- Issue in the same cycle does not affect that cycle's reads; reads see the pre-edge state.
- Write, on the clock edge: for each we[k] with wa[k]≠0, rf[wa[k]]←wd[k] and busy[wa[k]]←0.
  - Both ports writing the same address: port 1 data is stored.
  - Writing a non-busy register is legal (plain write).
- Issue, on the clock edge: iss_en with iss_rd≠0 sets busy[iss_rd]←1.
  - Issue and writeback to the same register in one cycle: data is written and busy ends at 1 (the new producer wins).
  - Issue to an already-busy register: stays busy; no error.
- Address 0: writes and issues are ignored; rf[0] is never modified.
- nbusy: equals popcount(busy) after every edge; it never exceeds NREGS−1.
- Reset: rf all 0, busy all 0, nbusy=0. Any we/iss_en in the reset cycle is discarded.

## Timing
- Read latency: 0 cycles (combinational from ra, we, wa, wd).
- Write latency: data visible through rf on the cycle after the edge; visible the same cycle via bypass when BYPASS=1.
- busy/rrdy: an issue at edge N gives rrdy=0 from cycle N+1. A writeback at edge M gives rrdy=1 in cycle M (with bypass) or M+1 (without).
- nbusy is registered and reflects busy after the same edge.
- Outputs during and immediately after reset: rd=0 for every address, rrdy all 1, nbusy=0.
- Reset asserted mid-operation: pending busy bits are lost. The pipeline flush upstream is responsible for consistency.

## Structure
- Package rf_pkg:
  - default constants XLEN_D=32, NREGS_D=32.
  - typedef wb_port_t {we, wa, wd}, parametrised via the module's AW/XLEN inside the module.
  - function popcount.
- Sub-module rf_read_port, instantiated NREAD times via generate: zero check, bypass priority mux, ready logic.
- busy vector and nbusy counter stay in the top module. nbusy is updated incrementally (+set, −cleared), not by a full popcount each cycle; it must match popcount.

## Test plan
- Reset, then reads of all addresses → rd=0, rrdy=1, nbusy=0. Write x5=0xDEADBEEF, read next cycle → 0xDEADBEEF.
- Write x0=0x1234 and issue x0 → read x0=0, nbusy stays 0.
- Issue x7 (nbusy→1, rrdy(x7)=0), writeback x7=0xA5 with BYPASS=1 → same cycle rd=0xA5, rrdy=1; next cycle nbusy=0.
- Both write ports target x3 (port0=0x11, port1=0x22) → stored and bypassed value 0x22.
- Same cycle: issue x9 and writeback x9=0x55 → rf[x9]=0x55, busy stays 1, nbusy unchanged at +1.
- Issue x1..x4 (nbusy=4), assert reset with we active → all rf 0, nbusy=0, the write discarded. Repeat with BYPASS=0: writeback read same cycle → old value, rrdy=0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the scoreboarded register file
package rf_pkg;
  localparam int XLEN_D = 32;
  localparam int NREGS_D = 32;
  function automatic logic [8:0] popcount(input logic [255:0] v);
    popcount = '0;
    for (int i = 0; i < 256; i++) popcount += 9'(v[i]);
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with zero check, writeback bypass and ready logic
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int AW = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 kill,
  input  logic [AW-1:0]        ra,
  input  logic [1:0]           we,
  input  logic [1:0][AW-1:0]   wa,
  input  logic [1:0][XLEN-1:0] wd,
  input  logic [XLEN-1:0]      rf_val,
  input  logic                 busy,
  output logic [XLEN-1:0]      rd,
  output logic                 rrdy
);
  logic zero, hit0, hit1;
  assign zero = kill || ra == '0;
  assign hit1 = BYPASS && we[1] && wa[1] == ra;
  assign hit0 = BYPASS && we[0] && wa[0] == ra;
  assign rd = zero ? '0 : hit1 ? wd[1] : hit0 ? wd[0] : rf_val;
  assign rrdy = zero || hit1 || hit0 || !busy;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two writeback ports, bypass and a busy scoreboard
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NREAD = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD-1:0][AW-1:0] ra,
  output logic [NREAD-1:0][XLEN-1:0] rd,
  output logic [NREAD-1:0]         rrdy,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_rd,
  input  logic [1:0]               we,
  input  logic [1:0][AW-1:0]       wa,
  input  logic [1:0][XLEN-1:0]     wd,
  output logic [AW:0]              nbusy
);
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
  } wb_port_t;
  wb_port_t wb [2];
  logic [XLEN-1:0] rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0] nbusy_q, nbusy_d;
  logic iss_hit, set_b, clr0, clr1;
  always_comb begin
    for (int k = 0; k < 2; k++) wb[k] = '{we[k], wa[k], wd[k]};
  end
  assign iss_hit = iss_en && iss_rd != '0;
  assign set_b = iss_hit && !busy_q[iss_rd];
  assign clr0 = wb[0].we && wb[0].wa != '0 && busy_q[wb[0].wa] && !(iss_hit && iss_rd == wb[0].wa);
  assign clr1 = wb[1].we && wb[1].wa != '0 && busy_q[wb[1].wa] && !(iss_hit && iss_rd == wb[1].wa)
             && !(wb[0].we && wb[0].wa == wb[1].wa);
  assign nbusy_d = nbusy_q + (AW+1)'(set_b) - (AW+1)'(clr0) - (AW+1)'(clr1);
  assign nbusy = nbusy_q;
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++) if (wb[k].we && wb[k].wa != '0) busy_d[wb[k].wa] = 1'b0;
    if (iss_hit) busy_d[iss_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q <= '{default: '0};
      busy_q <= '0;
      nbusy_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) if (wb[k].we && wb[k].wa != '0) rf_q[wb[k].wa] <= wb[k].wd;
      busy_q <= busy_d;
      nbusy_q <= nbusy_d;
      assert (9'(nbusy_q) == popcount(256'(busy_q)));
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rp
    rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp (
      .kill(reset), .ra(ra[i]), .we(we), .wa(wa), .wd(wd),
      .rf_val(rf_q[ra[i]]), .busy(busy_q[ra[i]]), .rd(rd[i]), .rrdy(rrdy[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven check of regfile_sb with and without bypass
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0][4:0] ra = '0;
  logic iss_en = 1'b0;
  logic [4:0] iss_rd = '0;
  logic [1:0] we = '0;
  logic [1:0][4:0] wa = '0;
  logic [1:0][31:0] wd = '0;
  logic [1:0][31:0] rd_b, rd_n;
  logic [1:0] ok_b, ok_n;
  logic [5:0] nb_b, nb_n;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  regfile_sb #(.BYPASS(1'b1)) u_b (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rrdy(ok_b), .iss_en(iss_en),
    .iss_rd(iss_rd), .we(we), .wa(wa), .wd(wd), .nbusy(nb_b)
  );
  regfile_sb #(.BYPASS(1'b0)) u_n (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .rrdy(ok_n), .iss_en(iss_en),
    .iss_rd(iss_rd), .we(we), .wa(wa), .wd(wd), .nbusy(nb_n)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    bit rst; bit iss; int ird; bit [1:0] w; int wa0; int wa1; bit [31:0] wd0; bit [31:0] wd1;
    int ra0; int ra1; bit [31:0] e0; bit k0; bit [31:0] e1; bit k1; int nb;
  } vec_t;
  vec_t v [21];
  task automatic drive(input bit r, input bit i, input int ir, input bit [1:0] w, input int a0,
                       input int a1, input bit [31:0] d0, input bit [31:0] d1, input int r0, input int r1);
    @(negedge clk);
    reset = r; iss_en = i; iss_rd = 5'(ir); we = w;
    wa[0] = 5'(a0); wa[1] = 5'(a1); wd[0] = d0; wd[1] = d1; ra[0] = 5'(r0); ra[1] = 5'(r1);
    #1;
  endtask
  initial begin
    v[0]  = '{0,0,0,2'b01, 5,0,32'hDEADBEEF,0,   5,0, 32'hDEADBEEF,1, 0,1, 0};
    v[1]  = '{0,0,0,2'b00, 0,0,0,0,              5,6, 32'hDEADBEEF,1, 0,1, 0};
    v[2]  = '{0,1,0,2'b01, 0,0,32'h1234,0,       0,5, 0,1, 32'hDEADBEEF,1, 0};
    v[3]  = '{0,0,0,2'b00, 0,0,0,0,              0,0, 0,1, 0,1, 0};
    v[4]  = '{0,1,7,2'b00, 0,0,0,0,              7,5, 0,1, 32'hDEADBEEF,1, 0};
    v[5]  = '{0,0,0,2'b00, 0,0,0,0,              7,5, 0,0, 32'hDEADBEEF,1, 1};
    v[6]  = '{0,0,0,2'b01, 7,0,32'hA5,0,         7,7, 32'hA5,1, 32'hA5,1, 1};
    v[7]  = '{0,0,0,2'b00, 0,0,0,0,              7,0, 32'hA5,1, 0,1, 0};
    v[8]  = '{0,0,0,2'b11, 3,3,32'h11,32'h22,    3,3, 32'h22,1, 32'h22,1, 0};
    v[9]  = '{0,0,0,2'b00, 0,0,0,0,              3,7, 32'h22,1, 32'hA5,1, 0};
    v[10] = '{0,1,9,2'b10, 0,9,0,32'h55,         9,3, 32'h55,1, 32'h22,1, 0};
    v[11] = '{0,0,0,2'b00, 0,0,0,0,              9,3, 32'h55,0, 32'h22,1, 1};
    v[12] = '{0,1,9,2'b00, 0,0,0,0,              9,0, 32'h55,0, 0,1, 1};
    v[13] = '{0,1,1,2'b00, 0,0,0,0,              9,0, 32'h55,0, 0,1, 1};
    v[14] = '{0,1,2,2'b01, 9,0,32'h66,0,         1,9, 0,0, 32'h66,1, 2};
    v[15] = '{0,1,3,2'b00, 0,0,0,0,              2,9, 0,0, 32'h66,1, 2};
    v[16] = '{0,1,4,2'b00, 0,0,0,0,              3,9, 32'h22,0, 32'h66,1, 3};
    v[17] = '{1,0,0,2'b01, 5,0,32'hBAD,0,        5,4, 0,1, 0,1, 4};
    v[18] = '{0,0,0,2'b00, 0,0,0,0,              5,3, 0,1, 0,1, 0};
    v[19] = '{0,0,0,2'b11, 10,11,32'hAA,32'hBB,  10,11, 32'hAA,1, 32'hBB,1, 0};
    v[20] = '{0,0,0,2'b00, 0,0,0,0,              10,11, 32'hAA,1, 32'hBB,1, 0};
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0, a, 31 - a);
      chk($sformatf("rst_rd_b[%0d]", a), rd_b[0], 0);
      chk($sformatf("rst_ok_b[%0d]", a), 32'(ok_b), 32'h3);
      chk($sformatf("rst_rd_n[%0d]", a), rd_n[1], 0);
      chk($sformatf("rst_ok_n[%0d]", a), 32'(ok_n), 32'h3);
    end
    chk("rst_nb_b", 32'(nb_b), 0);
    chk("rst_nb_n", 32'(nb_n), 0);
    for (int i = 0; i < 21; i++) begin
      drive(v[i].rst, v[i].iss, v[i].ird, v[i].w, v[i].wa0, v[i].wa1, v[i].wd0, v[i].wd1, v[i].ra0, v[i].ra1);
      chk($sformatf("v%0d_rd0", i), rd_b[0], v[i].e0);
      chk($sformatf("v%0d_rrdy0", i), 32'(ok_b[0]), 32'(v[i].k0));
      chk($sformatf("v%0d_rd1", i), rd_b[1], v[i].e1);
      chk($sformatf("v%0d_rrdy1", i), 32'(ok_b[1]), 32'(v[i].k1));
      chk($sformatf("v%0d_nbusy", i), 32'(nb_b), 32'(v[i].nb));
    end
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 7, 0, 32'h11, 0, 7, 0);
    chk("nb_wr_nobypass_rd", rd_n[0], 0);
    chk("nb_wr_nobypass_ok", 32'(ok_n[0]), 1);
    drive(0, 1, 7, 2'b00, 0, 0, 0, 0, 7, 0);
    chk("nb_after_wr_rd", rd_n[0], 32'h11);
    chk("nb_after_wr_nbusy", 32'(nb_n), 0);
    drive(0, 0, 0, 2'b01, 7, 0, 32'h22, 0, 7, 0);
    chk("nb_wb_same_cycle_rd", rd_n[0], 32'h11);
    chk("nb_wb_same_cycle_ok", 32'(ok_n[0]), 0);
    chk("nb_busy_count", 32'(nb_n), 1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 7, 0);
    chk("nb_wb_next_rd", rd_n[0], 32'h22);
    chk("nb_wb_next_ok", 32'(ok_n[0]), 1);
    chk("nb_wb_next_nbusy", 32'(nb_n), 0);
    for (int r = 1; r < 32; r++) drive(0, 1, r, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 31, 0);
    chk("nb_full_nbusy", 32'(nb_n), 31);
    chk("nb_full_ok", 32'(ok_n[0]), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
